// File: rtl/demux32bit_1x8_reg.sv
// Eight-entry 32-bit register array with two byte-enabled write ports.
// Port 0 has priority over port 1 on overlapping bytes; byte conflicts are flagged and counted.
module demux32bit_1x8_reg #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WR0_EN,
    input  logic [2:0]  WR0_SEL,
    input  logic [3:0]  WR0_BE,
    input  logic [31:0] WR0_DATA,
    input  logic        WR1_EN,
    input  logic [2:0]  WR1_SEL,
    input  logic [3:0]  WR1_BE,
    input  logic [31:0] WR1_DATA,
    output logic [31:0] Q0,
    output logic [31:0] Q1,
    output logic [31:0] Q2,
    output logic [31:0] Q3,
    output logic [31:0] Q4,
    output logic [31:0] Q5,
    output logic [31:0] Q6,
    output logic [31:0] Q7,
    output logic        WR_COLLIDE,
    output logic [7:0]  WR_CNT
);

    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];
    logic [7:0]  wr0_hit;
    logic [7:0]  wr1_hit;
    logic [3:0]  wr0_be_gated;
    logic [3:0]  wr1_be_gated;
    logic        collide_d;
    logic        collide_q;
    logic [7:0]  cnt_d;
    logic [7:0]  cnt_q;

    // Enables gate everything downstream so unknown SEL/BE/DATA on an idle port stays harmless.
    always_comb begin
        wr0_be_gated = WR0_EN ? WR0_BE : 4'b0000;
        wr1_be_gated = WR1_EN ? WR1_BE : 4'b0000;
        wr0_hit      = 8'h00;
        wr1_hit      = 8'h00;
        for (int k = 0; k < 8; k++) begin
            wr0_hit[k] = WR0_EN && (WR0_SEL == 3'(k));
            wr1_hit[k] = WR1_EN && (WR1_SEL == 3'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            regs_d[k] = regs_q[k];
            for (int b = 0; b < 4; b++) begin
                if (wr0_hit[k] && wr0_be_gated[b]) begin
                    regs_d[k][8*b +: 8] = WR0_DATA[8*b +: 8];
                end else if (wr1_hit[k] && wr1_be_gated[b]) begin
                    regs_d[k][8*b +: 8] = WR1_DATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        collide_d = WR0_EN && WR1_EN && (WR0_SEL == WR1_SEL)
                    && ((wr0_be_gated & wr1_be_gated) != 4'b0000);
        cnt_d = cnt_q;
        if (collide_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= RST_VAL;
            end
            collide_q <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= regs_d[k];
            end
            collide_q <= collide_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        Q0         = regs_q[0];
        Q1         = regs_q[1];
        Q2         = regs_q[2];
        Q3         = regs_q[3];
        Q4         = regs_q[4];
        Q5         = regs_q[5];
        Q6         = regs_q[6];
        Q7         = regs_q[7];
        WR_COLLIDE = collide_q;
        WR_CNT     = cnt_q;
    end

endmodule

// File: tb/tb_demux32bit_1x8_reg.sv
// Self-checking bench for demux32bit_1x8_reg: directed table, random traffic against a
// byte-mask reference model, counter saturation and asynchronous reset corners.
module tb_demux32bit_1x8_reg;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        en0, en1;
    logic [2:0]  sel0, sel1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1;
    logic [31:0] q [8];
    logic        collide;
    logic [7:0]  cnt;

    logic [31:0] mdl [8];
    logic        mcol;
    logic [7:0]  mcnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en0;
        logic [2:0]  sel0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        en1;
        logic [2:0]  sel1;
        logic [3:0]  be1;
        logic [31:0] d1;
        int          chk;
        logic [31:0] expv;
        logic        expc;
        logic [7:0]  expn;
    } vec_t;

    vec_t tbl [8];

    demux32bit_1x8_reg #(.RST_VAL(RV)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .WR0_EN     (en0),
        .WR0_SEL    (sel0),
        .WR0_BE     (be0),
        .WR0_DATA   (d0),
        .WR1_EN     (en1),
        .WR1_SEL    (sel1),
        .WR1_BE     (be1),
        .WR1_DATA   (d1),
        .Q0         (q[0]),
        .Q1         (q[1]),
        .Q2         (q[2]),
        .Q3         (q[3]),
        .Q4         (q[4]),
        .Q5         (q[5]),
        .Q6         (q[6]),
        .Q7         (q[7]),
        .WR_COLLIDE (collide),
        .WR_CNT     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mdl[k] = RV;
        mcol = 1'b0;
        mcnt = 8'h00;
    endtask

    // Reference: whole-word masks, port 1 mask trimmed by port 0's on a shared target.
    task automatic model_clock();
        logic [31:0] m0, m1;
        logic        same, c;
        m0   = bytemask(be0);
        m1   = bytemask(be1);
        same = en0 && en1 && (sel0 == sel1);
        if (same) m1 = m1 & ~m0;
        c = same && ((be0 & be1) != 4'b0000);
        if (en0) mdl[sel0] = (mdl[sel0] & ~m0) | (d0 & m0);
        if (en1) mdl[sel1] = (mdl[sel1] & ~m1) | (d1 & m1);
        mcol = c;
        if (c && mcnt != 8'hFF) mcnt = mcnt + 8'd1;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_q%0d", tag, k), q[k], mdl[k]);
        chk({tag, "_collide"}, {31'd0, collide}, {31'd0, mcol});
        chk({tag, "_cnt"}, {24'd0, cnt}, {24'd0, mcnt});
    endtask

    task automatic idle();
        en0 = 1'b0; en1 = 1'b0;
        sel0 = 3'd0; sel1 = 3'd0; be0 = 4'h0; be1 = 4'h0; d0 = 32'h0; d1 = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'd3, 4'hF, 32'h1234_5678, 1'b0, 3'd0, 4'h0, 32'h0,
                   3, 32'h1234_5678, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 3'd5, 4'hF, 32'h0000_0000, 1'b0, 3'd0, 4'h0, 32'h0,
                   5, 32'h0000_0000, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 3'd5, 4'h1, 32'h0000_00AA, 1'b1, 3'd5, 4'h2, 32'h0000_BB00,
                   5, 32'h0000_BBAA, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 3'd2, 4'hF, 32'h0000_0000, 1'b0, 3'd0, 4'h0, 32'h0,
                   2, 32'h0000_0000, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 3'd2, 4'hF, 32'h1111_1111, 1'b1, 3'd2, 4'hC, 32'h2222_2222,
                   2, 32'h1111_1111, 1'b1, 8'd1};
        tbl[5] = '{1'b0, 3'd3, 4'hF, 32'hFFFF_FFFF, 1'b0, 3'd3, 4'hF, 32'hEEEE_EEEE,
                   3, 32'h1234_5678, 1'b0, 8'd1};
        tbl[6] = '{1'b1, 3'd6, 4'h0, 32'h5555_5555, 1'b1, 3'd6, 4'h0, 32'h6666_6666,
                   6, RV, 1'b0, 8'd1};
        tbl[7] = '{1'b1, 3'd1, 4'h3, 32'hCAFE_F00D, 1'b1, 3'd7, 4'hC, 32'hBEEF_0000,
                   1, 32'hDEAD_F00D, 1'b0, 8'd1};

        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst_n = 1'b1;
        #1;

        for (int i = 0; i < 8; i++) begin
            en0 = tbl[i].en0; sel0 = tbl[i].sel0; be0 = tbl[i].be0; d0 = tbl[i].d0;
            en1 = tbl[i].en1; sel1 = tbl[i].sel1; be1 = tbl[i].be1; d1 = tbl[i].d1;
            step();
            chk($sformatf("vec%0d_reg", i), q[tbl[i].chk], tbl[i].expv);
            chk($sformatf("vec%0d_collide", i), {31'd0, collide}, {31'd0, tbl[i].expc});
            chk($sformatf("vec%0d_cnt", i), {24'd0, cnt}, {24'd0, tbl[i].expn});
            check_all($sformatf("vec%0d", i));
        end
        chk("vec7_q7", q[7], 32'hBEEF_BEEF);

        // Random traffic; targets confined to a few registers so conflicts are common.
        for (int i = 0; i < 400; i++) begin
            en0  = 1'($urandom_range(0, 3) != 0);
            en1  = 1'($urandom_range(0, 3) != 0);
            sel0 = 3'($urandom_range(0, (i < 200) ? 2 : 7));
            sel1 = 3'($urandom_range(0, (i < 200) ? 2 : 7));
            be0  = 4'($urandom);
            be1  = 4'($urandom);
            d0   = $urandom;
            d1   = $urandom;
            step();
            check_all("rand");
        end

        // Saturation: 300 back-to-back conflicts must pin the counter at FF.
        idle();
        step();
        for (int i = 0; i < 300; i++) begin
            en0 = 1'b1; en1 = 1'b1; sel0 = 3'd4; sel1 = 3'd4;
            be0 = 4'h8; be1 = 4'hF; d0 = $urandom; d1 = $urandom;
            step();
            if (i % 50 == 0) check_all("sat");
        end
        chk("sat_cnt_ff", {24'd0, cnt}, 32'h0000_00FF);
        chk("sat_collide", {31'd0, collide}, 32'd1);
        idle();
        step();
        chk("sat_hold_cnt", {24'd0, cnt}, 32'h0000_00FF);
        chk("sat_pulse_end", {31'd0, collide}, 32'd0);
        check_all("sat_idle");

        // Asynchronous reset mid-cycle with writes in flight.
        en0 = 1'b1; sel0 = 3'd0; be0 = 4'hF; d0 = 32'hA5A5_A5A5;
        en1 = 1'b1; sel1 = 3'd0; be1 = 4'hF; d1 = 32'h5A5A_5A5A;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #3 rst_n = 1'b1;
        #1;
        chk("rst_release_q0", q[0], RV);
        step();
        chk("resume_q0", q[0], 32'hA5A5_A5A5);
        chk("resume_collide", {31'd0, collide}, 32'd1);
        chk("resume_cnt", {24'd0, cnt}, 32'd1);
        check_all("resume");
        idle();
        step();
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
